// File: rtl/demux4_stream.sv
// Registered 1-to-4 valid/ready stream demultiplexer.
// The destination comes from in_sel or from a round-robin pointer. Each lane has a one-entry holding register.

module demux4_lane #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             i_acc,
  input  logic             i_drain,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_full,
  output logic [WIDTH-1:0] o_data
);
  logic             r_full;
  logic [WIDTH-1:0] r_data;

  // When a lane is accepted and drained in the same cycle, the accept wins.
  // The lane stays full and there is no bubble.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_full <= 1'b0;
      r_data <= '0;
    end else if (i_acc) begin
      r_full <= 1'b1;
      r_data <= i_data;
    end else if (i_drain) begin
      r_full <= 1'b0;
    end
  end

  assign o_full = r_full;
  assign o_data = r_data;
endmodule

module demux4_stream #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [1:0]       in_sel,
  input  logic             rr_en,
  output logic [3:0]       out_valid,
  input  logic [3:0]       out_ready,
  output logic [WIDTH-1:0] out_data0,
  output logic [WIDTH-1:0] out_data1,
  output logic [WIDTH-1:0] out_data2,
  output logic [WIDTH-1:0] out_data3,
  output logic [1:0]       rr_ptr
);
  localparam int NUM_LANES = 4;

  logic [1:0]                        r_rr_ptr;
  logic [1:0]                        w_dest;
  logic                              w_acc;
  logic [NUM_LANES-1:0]              w_full;
  logic [NUM_LANES-1:0][WIDTH-1:0]   w_data;

  assign w_dest   = rr_en ? r_rr_ptr : in_sel;
  // A stalled destination blocks the input. Round-robin never skips a lane.
  assign in_ready = ~w_full[w_dest] | out_ready[w_dest];
  assign w_acc    = in_valid & in_ready;

  for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
    demux4_lane #(.WIDTH(WIDTH)) u_lane (
      .clk     (clk),
      .reset_n (reset_n),
      .i_acc   (w_acc && (w_dest == 2'(gi))),
      .i_drain (w_full[gi] & out_ready[gi]),
      .i_data  (in_data),
      .o_full  (w_full[gi]),
      .o_data  (w_data[gi])
    );
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      r_rr_ptr <= 2'b00;
    else if (w_acc && rr_en)
      r_rr_ptr <= r_rr_ptr + 2'd1;
  end

  assign out_valid = w_full;
  assign out_data0 = w_data[0];
  assign out_data1 = w_data[1];
  assign out_data2 = w_data[2];
  assign out_data3 = w_data[3];
  assign rr_ptr    = r_rr_ptr;
endmodule

// File: tb/tb_demux4_stream.sv
// Directed bench for demux4_stream.
// A lane-array model is compared against the DUT every cycle, and literal checks pin the model.

module tb_demux4_stream;
  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [1:0]       in_sel;
  logic             rr_en;
  logic [3:0]       out_valid;
  logic [3:0]       out_ready;
  logic [WIDTH-1:0] out_data0, out_data1, out_data2, out_data3;
  logic [1:0]       rr_ptr;

  int n_tests = 0;
  int n_fail  = 0;

  demux4_stream #(.WIDTH(WIDTH)) dut (
    .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_sel(in_sel), .rr_en(rr_en), .out_valid(out_valid),
    .out_ready(out_ready), .out_data0(out_data0), .out_data1(out_data1),
    .out_data2(out_data2), .out_data3(out_data3), .rr_ptr(rr_ptr)
  );

  always #5 clk = ~clk;

  // Model: four slots, each with an occupied flag and a value, plus a pointer.
  bit       m_full [4];
  int       m_data [4];
  int       m_ptr;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 4; i++) begin m_full[i] = 0; m_data[i] = 0; end
      m_ptr = 0;
    end else begin
      int  d;
      bit  acc;
      d   = rr_en ? m_ptr : int'(in_sel);
      acc = in_valid && (!m_full[d] || out_ready[d]);
      for (int i = 0; i < 4; i++)
        if (m_full[i] && out_ready[i]) m_full[i] = 0;
      if (acc) begin
        m_full[d] = 1;
        m_data[d] = int'(in_data);
        if (rr_en) m_ptr = (m_ptr + 1) % 4;
      end
    end
  end

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  function automatic int lane_data(input int i);
    case (i)
      0: return int'(out_data0);
      1: return int'(out_data1);
      2: return int'(out_data2);
      default: return int'(out_data3);
    endcase
  endfunction

  // Per-cycle comparison against the model on the falling edge.
  always @(negedge clk) begin
    int d;
    d = rr_en ? m_ptr : int'(in_sel);
    check("cyc_in_ready", int'(in_ready), int'(!m_full[d] || out_ready[d]));
    check("cyc_rr_ptr", int'(rr_ptr), m_ptr);
    for (int i = 0; i < 4; i++) begin
      check("cyc_out_valid", int'(out_valid[i]), int'(m_full[i]));
      check("cyc_out_data", lane_data(i), m_data[i]);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input int sel, input int dat);
    in_valid = v;
    in_sel   = 2'(sel);
    in_data  = WIDTH'(dat);
  endtask

  initial begin
    reset_n = 1'b0; in_valid = 0; in_data = '0; in_sel = '0; rr_en = 0; out_ready = '0;
    repeat (2) step();
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_rr_ptr", int'(rr_ptr), 0);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_data0", int'(out_data0), 0);
    reset_n = 1'b1;
    step();

    // Explicit routing into four lanes with no output ready.
    for (int k = 0; k < 4; k++) begin drive(1, k, k * 5); step(); end
    drive(0, 0, 0);
    check("expl_valid", int'(out_valid), 4'b1111);
    check("expl_d0", int'(out_data0), 0);
    check("expl_d1", int'(out_data1), 5);
    check("expl_d2", int'(out_data2), 10);
    check("expl_d3", int'(out_data3), 15);
    out_ready = 4'hf; step(); out_ready = 4'h0;
    check("drain_valid", int'(out_valid), 0);
    check("drain_hold_d3", int'(out_data3), 15);

    // Back-pressure on lane 1.
    drive(1, 1, 5); step();
    drive(1, 1, 10); #1;
    check("bp_in_ready", int'(in_ready), 0);
    step(); step();
    check("bp_hold_d1", int'(out_data1), 5);
    out_ready = 4'b0010; #1;
    check("bp_release_ready", int'(in_ready), 1);
    step();
    out_ready = 4'b0000; drive(0, 0, 0);
    check("bp_new_d1", int'(out_data1), 10);
    check("bp_valid1", int'(out_valid[1]), 1);
    out_ready = 4'hf; step(); out_ready = 4'h0;

    // Round-robin with every output ready.
    rr_en = 1; out_ready = 4'hf;
    for (int k = 1; k <= 6; k++) begin
      drive(1, 0, k); step();
      check("rr_lane_data", lane_data((k - 1) % 4), k);
    end
    drive(0, 0, 0);
    check("rr_ptr_end", int'(rr_ptr), 2);
    step();

    // Round-robin stall with lane 2 held full.
    out_ready = 4'b1011;
    for (int k = 7; k <= 10; k++) begin drive(1, 0, k); step(); end
    drive(1, 0, 11); #1;
    check("stall_in_ready", int'(in_ready), 0);
    repeat (3) step();
    check("stall_ptr", int'(rr_ptr), 2);
    check("stall_valid", int'(out_valid), 4'b0100);
    check("stall_d0", int'(out_data0), 9);
    check("stall_d3", int'(out_data3), 8);
    out_ready = 4'hf; #1;
    check("stall_release", int'(in_ready), 1);
    step();
    drive(0, 0, 0);
    check("stall_d2", int'(out_data2), 11);
    check("stall_ptr_adv", int'(rr_ptr), 3);
    step();

    // Mid-stream asynchronous reset.
    rr_en = 0; out_ready = 4'h0;
    drive(1, 0, 1); step();
    drive(1, 1, 2); step();
    drive(1, 3, 3); step();
    drive(0, 0, 0);
    check("pre_rst_valid", int'(out_valid), 4'b1011);
    check("pre_rst_ptr", int'(rr_ptr), 3);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_ptr", int'(rr_ptr), 0);
    check("mid_rst_d1", int'(out_data1), 0);
    check("mid_rst_d3", int'(out_data3), 0);
    reset_n = 1'b1;
    step();

    // Switch between explicit routing and round-robin.
    rr_en = 1; out_ready = 4'hf;
    drive(1, 0, 4); step();
    rr_en = 0; drive(1, 3, 15); step();
    check("mode_d3", int'(out_data3), 15);
    check("mode_ptr_hold", int'(rr_ptr), 1);
    rr_en = 1; drive(1, 0, 9); step();
    drive(0, 0, 0);
    check("mode_d1", int'(out_data1), 9);
    check("mode_ptr_adv", int'(rr_ptr), 2);
    step();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
